// File: rtl/pim_pkg.sv
// Shared types for the PIM command scheduler: funct3 encodings,
// the queued command bundle and the scheduler FSM states.
package pim_pkg;

   localparam logic [2:0] PIM_WRITE   = 3'b001;
   localparam logic [2:0] PIM_COMPUTE = 3'b010;
   localparam logic [2:0] PIM_LOAD    = 3'b100;
   localparam logic [2:0] PIM_KEY     = 3'b101;
   localparam logic [2:0] PIM_VREF    = 3'b110;

   typedef struct packed {
      logic [2:0]  funct3;
      logic [3:0]  sel_pim;
      logic [12:0] size;
      logic [31:0] mem_addr;
   } pim_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } pim_state_t;

   function automatic logic is_legal(input logic [2:0] f);
      return f inside {PIM_WRITE, PIM_COMPUTE, PIM_LOAD, PIM_KEY, PIM_VREF};
   endfunction

endpackage

// File: rtl/pim_cmd_fifo.sv
// Synchronous command queue of DEPTH pim_cmd_t entries.
// The ready flag is a register so it has no path from the pop.
module pim_cmd_fifo
   import pim_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   push,
   input  pim_cmd_t               din,
   input  logic                   pop,
   output pim_cmd_t               head,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   pim_cmd_t      mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] next_level;

   assign head       = mem[rd_ptr];
   assign next_level = level + LW'(push) - LW'(pop);

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ready  <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= next_level;
         ready <= (next_level != LW'(DEPTH));
      end
   end

endmodule

// File: rtl/pim_cmd_sched.sv
// PIM command scheduler: queues commands and launches them on the DMA.
// Define PIM_SCHED_IRQ_EN to add the o_irq drain/error pulse output.
module pim_cmd_sched
   import pim_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TMO   = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [2:0]             i_cmd_funct3,
   input  logic [3:0]             i_cmd_sel_pim,
   input  logic [12:0]            i_cmd_size,
   input  logic [31:0]            i_cmd_mem_addr,
   output logic                   o_dma_en,
   output logic [2:0]             o_funct3,
   output logic [3:0]             o_sel_pim,
   output logic [12:0]            o_size,
   output logic [31:0]            o_mem_addr,
   input  logic                   i_dma_busy,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_idle,
   output logic [15:0]            o_done_cnt,
   output logic                   o_err,
   input  logic                   i_err_clr
`ifdef PIM_SCHED_IRQ_EN
   ,
   output logic                   o_irq
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TMO + 1);

   pim_state_t    state;
   pim_cmd_t      cmd_in;
   pim_cmd_t      head;
   logic          push;
   logic          pop;
   logic          bad;
   logic          zero;
   logic          skip;
   logic          tmo_hit;
   logic          dma_done;
   logic          set_err;
   logic          retire;
   logic          more;
   logic [TW-1:0] tcnt;

   assign cmd_in   = {i_cmd_funct3, i_cmd_sel_pim, i_cmd_size, i_cmd_mem_addr};
   assign push     = i_cmd_valid && o_cmd_ready;
   assign bad      = !is_legal(head.funct3);
   assign zero     = (head.size == '0);
   // Illegal and empty commands leave the queue without touching the DMA
   assign skip     = (state == ISSUE) && (bad || zero);
   assign tmo_hit  = (state == WAIT_BUSY) && !i_dma_busy
                   && (tcnt == TW'(TMO - 1));
   assign dma_done = (state == WAIT_DONE) && !i_dma_busy;
   assign pop      = skip || tmo_hit || dma_done;
   assign set_err  = ((state == ISSUE) && bad) || tmo_hit;
   assign retire   = ((state == ISSUE) && !bad && zero) || dma_done;
   assign more     = (o_level > LW'(1)) || push;
   assign o_idle   = (o_level == '0) && (state == IDLE);

   pim_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push),
      .din     (cmd_in),
      .pop     (pop),
      .head    (head),
      .level   (o_level),
      .ready   (o_cmd_ready)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         tcnt       <= '0;
         o_dma_en   <= 1'b0;
         o_funct3   <= '0;
         o_sel_pim  <= '0;
         o_size     <= '0;
         o_mem_addr <= '0;
         o_done_cnt <= '0;
         o_err      <= 1'b0;
      end else begin
         o_dma_en <= 1'b0;
         if (retire) o_done_cnt <= o_done_cnt + 16'd1;
         if (set_err)        o_err <= 1'b1;
         else if (i_err_clr) o_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (o_level != '0) state <= ISSUE;
            end
            ISSUE: begin
               if (skip) begin
                  state <= IDLE;
               end else begin
                  o_dma_en   <= 1'b1;
                  o_funct3   <= head.funct3;
                  o_sel_pim  <= head.sel_pim;
                  o_size     <= head.size;
                  o_mem_addr <= head.mem_addr;
                  tcnt       <= '0;
                  state      <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (i_dma_busy)   state <= WAIT_DONE;
               else if (tmo_hit) state <= IDLE;
               else              tcnt  <= tcnt + TW'(1);
            end
            WAIT_DONE: begin
               if (!i_dma_busy) state <= more ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PIM_SCHED_IRQ_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_irq <= 1'b0;
      else          o_irq <= (pop && (o_level == LW'(1)) && !push)
                           || (set_err && !o_err);
   end
`endif

endmodule

// File: tb/tb_pim_cmd_sched.sv
// Self-checking bench for pim_cmd_sched: directed scenarios plus a
// randomized run against a transaction-level queue model.
module tb_pim_cmd_sched;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   typedef logic [51:0] ent_t;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic [2:0]  i_cmd_funct3;
   logic [3:0]  i_cmd_sel_pim;
   logic [12:0] i_cmd_size;
   logic [31:0] i_cmd_mem_addr;
   logic        o_dma_en;
   logic [2:0]  o_funct3;
   logic [3:0]  o_sel_pim;
   logic [12:0] o_size;
   logic [31:0] o_mem_addr;
   logic        i_dma_busy;
   logic [2:0]  o_level;
   logic        o_idle;
   logic [15:0] o_done_cnt;
   logic        o_err;
   logic        i_err_clr;
`ifdef PIM_SCHED_IRQ_EN
   logic        o_irq;
   int          irq_cnt = 0;
   always @(negedge i_clk) if (o_irq === 1'b1) irq_cnt++;
`endif

   pim_cmd_sched #(.DEPTH(DEPTH), .TMO(TMO)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_cmd_valid    (i_cmd_valid),
      .o_cmd_ready    (o_cmd_ready),
      .i_cmd_funct3   (i_cmd_funct3),
      .i_cmd_sel_pim  (i_cmd_sel_pim),
      .i_cmd_size     (i_cmd_size),
      .i_cmd_mem_addr (i_cmd_mem_addr),
      .o_dma_en       (o_dma_en),
      .o_funct3       (o_funct3),
      .o_sel_pim      (o_sel_pim),
      .o_size         (o_size),
      .o_mem_addr     (o_mem_addr),
      .i_dma_busy     (i_dma_busy),
      .o_level        (o_level),
      .o_idle         (o_idle),
      .o_done_cnt     (o_done_cnt),
      .o_err          (o_err),
      .i_err_clr      (i_err_clr)
`ifdef PIM_SCHED_IRQ_EN
      ,
      .o_irq          (o_irq)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int   n_pass   = 0;
   int   n_total  = 0;
   int   zero_cnt = 0;
   int   ok_cnt   = 0;
   logic exp_err  = 1'b0;
   bit   hold_en  = 1'b1;
   ent_t issued[$];
   ent_t exp_issue[$];
   int   plan_d[$];
   int   plan_l[$];

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit legal(input logic [2:0] f);
      return f == 3'b001 || f == 3'b010 || f == 3'b100
          || f == 3'b101 || f == 3'b110;
   endfunction

   // Behavioural DMA: answers each launch after d cycles, busy for l cycles
   initial begin : dma_model
      int   d;
      int   l;
      ent_t rec;
      i_dma_busy = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_dma_en === 1'b1) begin
            rec = {o_funct3, o_sel_pim, o_size, o_mem_addr};
            issued.push_back(rec);
            if (plan_d.size() != 0) begin
               d = plan_d.pop_front();
               l = plan_l.pop_front();
            end else begin
               d = $urandom_range(0, TMO + 3);
               l = $urandom_range(1, 6);
            end
            if (d >= TMO) begin
               exp_err = 1'b1;
            end else begin
               repeat (d) @(negedge i_clk);
               i_dma_busy = 1'b1;
               repeat (l) @(negedge i_clk);
               if (hold_en)
                  check("field_hold", {o_funct3, o_sel_pim, o_size, o_mem_addr}, rec);
               i_dma_busy = 1'b0;
               ok_cnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [2:0] f, input logic [3:0] s,
                       input logic [12:0] z, input logic [31:0] a);
      int n;
      n = 0;
      while (o_cmd_ready !== 1'b1 && n < 500) begin
         @(negedge i_clk);
         n++;
      end
      check("push_ready_bound", n < 500, 1);
      i_cmd_valid    = 1'b1;
      i_cmd_funct3   = f;
      i_cmd_sel_pim  = s;
      i_cmd_size     = z;
      i_cmd_mem_addr = a;
      @(posedge i_clk);
      if (!legal(f))      exp_err = 1'b1;
      else if (z == '0)   zero_cnt++;
      else                exp_issue.push_back({f, s, z, a});
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      @(negedge i_clk);
      while (!(o_idle === 1'b1 && i_dma_busy == 1'b0) && n < 3000) begin
         @(negedge i_clk);
         n++;
      end
      check(tag, n < 3000, 1);
   endtask

   task automatic cmp_issues(input string tag);
      check({tag, "_count"}, issued.size(), exp_issue.size());
      while (issued.size() != 0 && exp_issue.size() != 0)
         check({tag, "_order"}, issued.pop_front(), exp_issue.pop_front());
      issued.delete();
      exp_issue.delete();
   endtask

   task automatic clr_err();
      @(negedge i_clk);
      i_err_clr = 1'b1;
      @(negedge i_clk);
      i_err_clr = 1'b0;
      exp_err   = 1'b0;
   endtask

   initial begin
      int n;
      logic [2:0] f;
      logic [2:0] legal_tab [5];
      legal_tab = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
      i_rst_n = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_funct3 = '0;
      i_cmd_sel_pim = '0;
      i_cmd_size = '0;
      i_cmd_mem_addr = '0;
      i_err_clr = 1'b0;
      repeat (3) @(negedge i_clk);
      check("rst_ready", o_cmd_ready, 1);
      check("rst_idle", o_idle, 1);
      check("rst_level", o_level, 0);
      check("rst_dma_en", o_dma_en, 0);
      check("rst_err", o_err, 0);
      check("rst_done", o_done_cnt, 0);
      check("rst_fields", {o_funct3, o_sel_pim, o_size, o_mem_addr}, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // single command: two-cycle launch latency, 20-cycle busy
      plan_d.push_back(0);
      plan_l.push_back(20);
      push(3'b010, 4'd3, 13'd16, 32'h1000);
      check("lat_c0_en", o_dma_en, 0);
      check("lat_c0_idle", o_idle, 0);
      @(negedge i_clk);
      check("lat_c1_en", o_dma_en, 0);
      @(negedge i_clk);
      check("lat_c2_en", o_dma_en, 1);
      check("lat_c2_fields", {o_funct3, o_sel_pim, o_size, o_mem_addr},
            {3'b010, 4'd3, 13'd16, 32'h1000});
      @(negedge i_clk);
      check("lat_c3_en", o_dma_en, 0);
      wait_idle("single_idle_bound");
      check("single_done", o_done_cnt, 16'(zero_cnt + ok_cnt));
      check("single_idle", o_idle, 1);
      cmp_issues("single");
`ifdef PIM_SCHED_IRQ_EN
      check("irq_drain", irq_cnt, 1);
`endif

      // five back-to-back commands into a four-entry queue
      for (int i = 0; i < 5; i++) begin
         plan_d.push_back(2);
         plan_l.push_back(3);
      end
      for (int i = 0; i < 4; i++)
         push(legal_tab[i], 4'(i + 1), 13'(100 + i), 32'h2000 + 32'(i));
      check("full_ready", o_cmd_ready, 0);
      check("full_level", o_level, 4);
      push(legal_tab[4], 4'd9, 13'd200, 32'h2004);
      wait_idle("burst_idle_bound");
      cmp_issues("burst");
      check("burst_done", o_done_cnt, 16'(zero_cnt + ok_cnt));

      // illegal funct3 is discarded and flags an error
      push(3'b011, 4'd1, 13'd8, 32'h3000);
      wait_idle("illegal_idle_bound");
      check("illegal_err", o_err, exp_err);
      cmp_issues("illegal");
      clr_err();
      check("err_clr", o_err, 0);

      // zero-size command retires without a launch
      push(3'b001, 4'd2, 13'd0, 32'h4000);
      wait_idle("zero_idle_bound");
      check("zero_done", o_done_cnt, 16'(zero_cnt + ok_cnt));
      cmp_issues("zero");

      // busy never rises: timeout after TMO cycles, next command issues
      plan_d.push_back(TMO);
      plan_l.push_back(1);
      plan_d.push_back(0);
      plan_l.push_back(2);
      push(3'b100, 4'd5, 13'd32, 32'h5000);
      push(3'b101, 4'd6, 13'd48, 32'h5100);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (o_dma_en !== 1'b1 && n < 50);
      check("tmo_launch_bound", n < 50, 1);
      repeat (TMO - 1) @(negedge i_clk);
      check("tmo_err_early", o_err, 0);
      @(negedge i_clk);
      check("tmo_err_set", o_err, 1);
      repeat (2) @(negedge i_clk);
      check("tmo_next_en", o_dma_en, 1);
      check("tmo_next_addr", o_mem_addr, 32'h5100);
      wait_idle("tmo_idle_bound");
      cmp_issues("tmo");
      check("tmo_done", o_done_cnt, 16'(zero_cnt + ok_cnt));
      check("tmo_err_sticky", o_err, exp_err);
      clr_err();

      // clear coinciding with an error set: the set wins
      push(3'b111, 4'd0, 13'd4, 32'h6000);
      @(negedge i_clk);
      i_err_clr = 1'b1;
      @(negedge i_clk);
      i_err_clr = 1'b0;
      check("set_wins", o_err, 1);
      @(negedge i_clk);
      check("set_wins_hold", o_err, 1);
      clr_err();
      check("set_wins_clr", o_err, 0);

      // randomized traffic against the queue model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) f = ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b111;
         else f = legal_tab[$urandom_range(0, 4)];
         push(f, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0) ? 13'd0 : 13'($urandom_range(1, 8191)),
              $urandom);
         repeat ($urandom_range(0, 3)) @(negedge i_clk);
      end
      wait_idle("rand_idle_bound");
      cmp_issues("rand");
      check("rand_done", o_done_cnt, 16'(zero_cnt + ok_cnt));
      check("rand_err", o_err, exp_err);
      check("rand_level", o_level, 0);
      clr_err();

      // reset while a command is in flight with three more queued
      hold_en = 1'b0;
      plan_d.push_back(0);
      plan_l.push_back(30);
      for (int i = 0; i < 4; i++)
         push(3'b010, 4'd1, 13'd64, 32'h7000 + 32'(i));
      n = 0;
      while (i_dma_busy !== 1'b1 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      check("rstmid_busy_bound", n < 50, 1);
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check("rstmid_level", o_level, 0);
      check("rstmid_dma_en", o_dma_en, 0);
      check("rstmid_done", o_done_cnt, 0);
      check("rstmid_ready", o_cmd_ready, 1);
      check("rstmid_idle", o_idle, 1);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      n = 0;
      while (i_dma_busy !== 1'b0 && n < 60) begin
         @(negedge i_clk);
         n++;
      end
      check("rstmid_release_bound", n < 60, 1);
      issued.delete();
      repeat (6) @(negedge i_clk);
      check("rstmid_no_reissue", issued.size(), 0);
      check("rstmid_done_after", o_done_cnt, 0);
      check("rstmid_idle_after", o_idle, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
